// File: rtl/rssi_anomaly_decision_if.sv
// Bus bundle for rssi_anomaly_decision: the decision request from the EWMA
// block, the runtime controls, and every status output toward the HIDS core.
// The master side drives requests; the slave side is the decision block.
interface rssi_anomaly_decision_if;
    logic        EnableDecision;
    logic [31:0] ewma_rssi;
    logic [31:0] rssi;
    logic [31:0] threshold;
    logic        alarm_clr;
    logic        decision_valid;
    logic        anomaly;
    logic [31:0] deviation;
    logic [7:0]  anomaly_run;
    logic        alarm;
    logic [15:0] total_cnt;
    logic [15:0] anom_cnt;

    modport master (
        output EnableDecision, ewma_rssi, rssi, threshold, alarm_clr,
        input  decision_valid, anomaly, deviation, anomaly_run, alarm,
               total_cnt, anom_cnt
    );

    modport slave (
        input  EnableDecision, ewma_rssi, rssi, threshold, alarm_clr,
        output decision_valid, anomaly, deviation, anomaly_run, alarm,
               total_cnt, anom_cnt
    );
endinterface

// File: rtl/rssi_anomaly_decision.sv
// rssi_anomaly_decision: consumes the EWMA update pulse, measures how far the
// raw RSSI sample sits from the running average, flags outliers above a
// programmable threshold after a warm-up window, and raises a sticky alarm
// after a run of consecutive outliers.
// Optional feature: define DECISION_STATS_EN to build the saturating
// decision/anomaly statistics counters; otherwise those outputs read zero.
module rssi_anomaly_decision #(
    parameter int unsigned WARMUP    = 8,
    parameter int unsigned ALARM_RUN = 3
) (
    input  logic                         clk_h,
    input  logic                         rst_h,
    rssi_anomaly_decision_if.slave       bus
);

    localparam logic [7:0] WARMUP_LAST = 8'(WARMUP);
    localparam logic [7:0] ALARM_LIMIT = 8'(ALARM_RUN);

    typedef enum logic [1:0] {
        MODE_WARMUP = 2'd0,
        MODE_ARMED  = 2'd1,
        MODE_ALARM  = 2'd2
    } mode_t;

    // Sign-magnitude to 33-bit two's complement; negative zero maps to zero
    // because negating a zero magnitude yields zero.
    function automatic logic [32:0] to_twos(input logic [31:0] sm);
        logic [32:0] mag;
        mag = {2'b00, sm[30:0]};
        return sm[31] ? (~mag + 33'd1) : mag;
    endfunction

    logic        cap_valid;
    logic [32:0] cap_rssi;
    logic [32:0] cap_ewma;

    logic [32:0] eval_diff;
    logic [31:0] eval_dev;
    logic        eval_anom;

    mode_t       mode, mode_nx;
    logic [7:0]  warm_cnt, warm_nx;
    logic [7:0]  run_cnt, run_nx;
    logic        alarm_q, alarm_nx;

    logic        valid_q;
    logic        anomaly_q;
    logic [31:0] deviation_q;

    // Capture stage: register both operands already in two's complement.
    always_ff @(posedge clk_h or negedge rst_h) begin
        if (!rst_h) begin
            cap_valid <= 1'b0;
            cap_rssi  <= '0;
            cap_ewma  <= '0;
        end else begin
            cap_valid <= bus.EnableDecision;
            if (bus.EnableDecision) begin
                cap_rssi <= to_twos(bus.rssi);
                cap_ewma <= to_twos(bus.ewma_rssi);
            end
        end
    end

    // Evaluate stage arithmetic: |diff| is below 2^32, so the low 32 bits of
    // the negated difference are exact and the top bit can be dropped.
    always_comb begin
        eval_diff = cap_rssi - cap_ewma;
        eval_dev  = eval_diff[32] ? (~eval_diff[31:0] + 32'd1) : eval_diff[31:0];
        eval_anom = (mode != MODE_WARMUP) && (eval_dev > bus.threshold);
    end

    // Mode FSM next state: warm-up counting, run tracking, alarm raise/clear;
    // a clear pulse overrides whatever the concurrent evaluation would do.
    always_comb begin
        mode_nx  = mode;
        warm_nx  = warm_cnt;
        run_nx   = run_cnt;
        alarm_nx = alarm_q;

        if (cap_valid) begin
            if (mode == MODE_WARMUP) begin
                warm_nx = warm_cnt + 8'd1;
                if (warm_cnt + 8'd1 == WARMUP_LAST) begin
                    mode_nx = MODE_ARMED;
                end
            end else if (eval_anom) begin
                run_nx = (run_cnt == 8'hFF) ? run_cnt : run_cnt + 8'd1;
            end else begin
                run_nx = 8'd0;
            end
        end

        if (bus.alarm_clr) begin
            run_nx   = 8'd0;
            alarm_nx = 1'b0;
            if (mode == MODE_ALARM) begin
                mode_nx = MODE_ARMED;
            end
        end else if (cap_valid && (mode == MODE_ARMED) && (run_nx >= ALARM_LIMIT)) begin
            alarm_nx = 1'b1;
            mode_nx  = MODE_ALARM;
        end
    end

    // Mode FSM state register together with its counters and the alarm flag.
    always_ff @(posedge clk_h or negedge rst_h) begin
        if (!rst_h) begin
            mode     <= MODE_WARMUP;
            warm_cnt <= 8'd0;
            run_cnt  <= 8'd0;
            alarm_q  <= 1'b0;
        end else begin
            mode     <= mode_nx;
            warm_cnt <= warm_nx;
            run_cnt  <= run_nx;
            alarm_q  <= alarm_nx;
        end
    end

    // Decision result registers; anomaly and deviation hold between decisions.
    always_ff @(posedge clk_h or negedge rst_h) begin
        if (!rst_h) begin
            valid_q     <= 1'b0;
            anomaly_q   <= 1'b0;
            deviation_q <= '0;
        end else begin
            valid_q <= cap_valid;
            if (cap_valid) begin
                anomaly_q   <= eval_anom;
                deviation_q <= eval_dev;
            end
        end
    end

    assign bus.decision_valid = valid_q;
    assign bus.anomaly        = anomaly_q;
    assign bus.deviation      = deviation_q;
    assign bus.anomaly_run    = run_cnt;
    assign bus.alarm          = alarm_q;

`ifdef DECISION_STATS_EN
    logic [15:0] total_q;
    logic [15:0] anom_q;

    // Saturating statistics; only reset clears them.
    always_ff @(posedge clk_h or negedge rst_h) begin
        if (!rst_h) begin
            total_q <= '0;
            anom_q  <= '0;
        end else if (cap_valid) begin
            if (total_q != 16'hFFFF) begin
                total_q <= total_q + 16'd1;
            end
            if (eval_anom && (anom_q != 16'hFFFF)) begin
                anom_q <= anom_q + 16'd1;
            end
        end
    end

    assign bus.total_cnt = total_q;
    assign bus.anom_cnt  = anom_q;
`else
    assign bus.total_cnt = '0;
    assign bus.anom_cnt  = '0;
`endif

endmodule

// File: tb/tb_rssi_anomaly_decision.sv
// Testbench for rssi_anomaly_decision: directed scenarios followed by random
// traffic, checked by a queue-based scoreboard fed from an arithmetic model.
module tb_rssi_anomaly_decision;

    localparam int WARMUP    = 2;
    localparam int ALARM_RUN = 3;

    logic clk_h = 1'b0;
    logic rst_h = 1'b0;

    rssi_anomaly_decision_if bus();

    rssi_anomaly_decision #(
        .WARMUP    (WARMUP),
        .ALARM_RUN (ALARM_RUN)
    ) dut (
        .clk_h (clk_h),
        .rst_h (rst_h),
        .bus   (bus.slave)
    );

    always #5 clk_h = ~clk_h;

    int cyc = 0;
    always @(posedge clk_h) cyc++;

    typedef struct {
        int          at_cycle;
        logic [31:0] dev;
        logic        anom;
        logic [7:0]  run;
        logic        alarm;
        logic [15:0] total;
        logic [15:0] acnt;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Reference model state: decisions since reset, run length, alarm, stats.
    int          m_done;
    int          m_run;
    bit          m_alarm;
    int          m_total;
    int          m_anom;
    bit          pend;
    logic [31:0] pend_e;
    logic [31:0] pend_s;
    logic [31:0] cur_thr;

    task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic longint smValue(input logic [31:0] x);
        longint v;
        v = 0;
        v[30:0] = x[30:0];
        return x[31] ? -v : v;
    endfunction

    task automatic resetModel();
        m_done  = 0;
        m_run   = 0;
        m_alarm = 0;
        m_total = 0;
        m_anom  = 0;
        pend    = 0;
        sb.delete();
    endtask

    // One decision evaluated with the threshold and clear seen in its EVAL cycle.
    task automatic modelEval(input logic [31:0] thr, input bit clr);
        longint dev;
        longint t;
        bit     warm;
        bit     anom;
        exp_t   e;
        dev = smValue(pend_s) - smValue(pend_e);
        if (dev < 0) dev = -dev;
        t = 0;
        t[31:0] = thr;
        warm = (m_done < WARMUP);
        anom = !warm && (dev > t);
        if (clr) begin
            m_run   = 0;
            m_alarm = 0;
        end else if (!warm) begin
            m_run = anom ? ((m_run < 255) ? m_run + 1 : 255) : 0;
            if (m_run >= ALARM_RUN) m_alarm = 1;
        end
        m_done++;
        if (m_total < 65535) m_total++;
        if (anom && m_anom < 65535) m_anom++;
        e.at_cycle = cyc + 1;
        e.dev      = dev[31:0];
        e.anom     = anom;
        e.run      = 8'(m_run);
        e.alarm    = m_alarm;
`ifdef DECISION_STATS_EN
        e.total    = 16'(m_total);
        e.acnt     = 16'(m_anom);
`else
        e.total    = 16'd0;
        e.acnt     = 16'd0;
`endif
        sb.push_back(e);
    endtask

    // Live run/alarm must match the model state reached at the previous edge.
    task automatic checkOutput();
        compareVal("anomaly_run", 32'(bus.anomaly_run), 32'(m_run));
        compareVal("alarm", 32'(bus.alarm), 32'(m_alarm));
    endtask

    task automatic checkAllZero(input string tag);
        compareVal({tag, "_valid"}, 32'(bus.decision_valid), 32'd0);
        compareVal({tag, "_anomaly"}, 32'(bus.anomaly), 32'd0);
        compareVal({tag, "_deviation"}, bus.deviation, 32'd0);
        compareVal({tag, "_run"}, 32'(bus.anomaly_run), 32'd0);
        compareVal({tag, "_alarm"}, 32'(bus.alarm), 32'd0);
        compareVal({tag, "_total"}, 32'(bus.total_cnt), 32'd0);
        compareVal({tag, "_anomcnt"}, 32'(bus.anom_cnt), 32'd0);
    endtask

    // Drive one cycle of inputs and advance the model for the upcoming edge.
    task automatic applyStimulus(input bit pulse, input logic [31:0] e, input logic [31:0] s,
                                 input logic [31:0] thr, input bit clr);
        @(negedge clk_h);
        checkOutput();
        bus.EnableDecision = pulse;
        bus.ewma_rssi      = e;
        bus.rssi           = s;
        bus.threshold      = thr;
        bus.alarm_clr      = clr;
        if (pend) begin
            modelEval(thr, clr);
        end else if (clr) begin
            m_run   = 0;
            m_alarm = 0;
        end
        pend   = pulse;
        pend_e = e;
        pend_s = s;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'd0, 32'd0, cur_thr, 1'b0);
    endtask

    function automatic logic [31:0] randSm();
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0:       v = 32'($urandom_range(0, 200));
            1:       v = {1'b0, 31'($urandom)};
            2:       v = 32'd0;
            default: v = 32'h7FFF_FFFF;
        endcase
        v[31] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    // Scoreboard monitor: every decision_valid pops and checks one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_h);
            if (rst_h && bus.decision_valid) begin
                compareVal("valid_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    compareVal("latency_cycle", 32'(cyc), 32'(e.at_cycle));
                    compareVal("deviation", bus.deviation, e.dev);
                    compareVal("anomaly", 32'(bus.anomaly), 32'(e.anom));
                    compareVal("dv_anomaly_run", 32'(bus.anomaly_run), 32'(e.run));
                    compareVal("dv_alarm", 32'(bus.alarm), 32'(e.alarm));
                    compareVal("total_cnt", 32'(bus.total_cnt), 32'(e.total));
                    compareVal("anom_cnt", 32'(bus.anom_cnt), 32'(e.acnt));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        bus.EnableDecision = 1'b0;
        bus.ewma_rssi      = '0;
        bus.rssi           = '0;
        bus.threshold      = '0;
        bus.alarm_clr      = 1'b0;
        cur_thr            = 32'd10;
        resetModel();

        repeat (2) @(negedge clk_h);
        checkAllZero("reset");
        rst_h = 1'b1;

        $display("[TB] warm-up phase");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h8000_0050, 32'h8000_0064, cur_thr, 1'b0);
            idle(1);
        end
        idle(2);

        $display("[TB] back-to-back phase");
        applyStimulus(1'b1, 32'h0000_0010, 32'h0000_0030, cur_thr, 1'b0);
        applyStimulus(1'b1, 32'h8000_0007, 32'h0000_0002, cur_thr, 1'b0);
        idle(3);

        $display("[TB] sign handling phase");
        cur_thr = 32'd8;
        applyStimulus(1'b1, 32'h8000_0005, 32'h0000_0003, cur_thr, 1'b0);
        applyStimulus(1'b1, 32'h8000_0000, 32'h0000_0000, cur_thr, 1'b0);
        idle(3);

        $display("[TB] alarm phase");
        cur_thr = 32'd10;
        applyStimulus(1'b1, 32'd5, 32'd5, cur_thr, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h8000_0050, 32'h8000_0064, cur_thr, 1'b0);
        idle(2);
        applyStimulus(1'b1, 32'd5, 32'd5, cur_thr, 1'b0);
        idle(2);
        applyStimulus(1'b0, 32'd0, 32'd0, cur_thr, 1'b1);
        idle(2);

        $display("[TB] clear collision phase");
        applyStimulus(1'b1, 32'd5, 32'd5, cur_thr, 1'b0);
        applyStimulus(1'b1, 32'h8000_0050, 32'h8000_0064, cur_thr, 1'b0);
        applyStimulus(1'b1, 32'h8000_0050, 32'h8000_0064, cur_thr, 1'b0);
        applyStimulus(1'b1, 32'h8000_0050, 32'h8000_0064, cur_thr, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'd0, cur_thr, 1'b1);
        idle(3);

        $display("[TB] reset mid-operation phase");
        applyStimulus(1'b1, 32'h8000_0050, 32'h0000_0064, cur_thr, 1'b0);
        @(posedge clk_h);
        #1 rst_h = 1'b0;
        resetModel();
        @(negedge clk_h);
        bus.EnableDecision = 1'b0;
        bus.alarm_clr      = 1'b0;
        checkAllZero("midreset");
        repeat (2) @(negedge clk_h);
        checkAllZero("midreset_hold");
        rst_h = 1'b1;

        $display("[TB] statistics phase");
        applyStimulus(1'b1, 32'h8000_0050, 32'h8000_0064, cur_thr, 1'b0);
        applyStimulus(1'b1, 32'h8000_0050, 32'h8000_0064, cur_thr, 1'b0);
        applyStimulus(1'b1, 32'h8000_0050, 32'h8000_0064, cur_thr, 1'b0);
        applyStimulus(1'b1, 32'h8000_0050, 32'h8000_0064, cur_thr, 1'b0);
        applyStimulus(1'b1, 32'd7, 32'd7, cur_thr, 1'b0);
        idle(3);
`ifdef DECISION_STATS_EN
        compareVal("stats_total_5", 32'(bus.total_cnt), 32'd5);
        compareVal("stats_anom_2", 32'(bus.anom_cnt), 32'd2);
`else
        compareVal("stats_total_tied", 32'(bus.total_cnt), 32'd0);
        compareVal("stats_anom_tied", 32'(bus.anom_cnt), 32'd0);
`endif

        $display("[TB] random phase");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                cur_thr = 32'($urandom);
            end else if ($urandom_range(0, 3) == 0) begin
                cur_thr = 32'($urandom_range(0, 150));
            end
            applyStimulus(1'($urandom_range(0, 1)), randSm(), randSm(), cur_thr,
                          ($urandom_range(0, 15) == 0));
        end

        for (int i = 0; i < 20 && (pend || sb.size() > 0); i++) idle(1);
        idle(1);
        compareVal("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rssi_anomaly_decision.md
# rssi_anomaly_decision

Consumer side of the RSSI EWMA block: sits downstream of the exponentially weighted moving average unit and acts on its `EnableDecision` pulse. Each pulse latches the current raw RSSI sample and the updated `ewma_rssi`, computes their absolute deviation, and flags the sample anomalous when the deviation exceeds a programmable threshold. Consecutive anomalies are counted and raise a sticky alarm toward the HIDS core. A warm-up window suppresses decisions while the average settles.

## Interface
Parameters:
- `WARMUP`, 8: number of initial decisions forced non-anomalous (1..255).
- `ALARM_RUN`, 3: consecutive anomalies that raise `alarm` (1..255).

Ports:
- `clk_h`  in  1  system clock, rising edge.
- `rst_h`  in  1  reset; asynchronous, active-low.
- `EnableDecision`  in  1  one-cycle pulse from the EWMA block: `ewma_rssi` has just been updated.
- `ewma_rssi`  in  32  sign-magnitude average; bit 31 is the sign, bits 30:0 are the magnitude.
- `rssi`  in  32  sign-magnitude raw sample; stable in the cycle `EnableDecision` is high.
- `threshold`  in  32  unsigned deviation threshold.
- `alarm_clr`  in  1  one-cycle pulse that clears the alarm and the run counter.
- `decision_valid`  out  1  one-cycle pulse: `anomaly` and `deviation` are valid.
- `anomaly`  out  1  per-decision anomaly flag.
- `deviation`  out  32  unsigned value of abs(`rssi` − `ewma_rssi`) for the last decision.
- `anomaly_run`  out  8  consecutive-anomaly count, saturating at 255.
- `alarm`  out  1  sticky alarm.
- `total_cnt`  out  16  decisions made, saturating.
- `anom_cnt`  out  16  anomalies flagged, saturating.

## Operation
- Two-stage pipeline. It sustains one decision per cycle.
  - **CAPTURE:** on an edge where `EnableDecision`=1, convert both operands to 33-bit two's complement and register them. −0 (0x8000_0000) converts to 0.
  - **EVAL:** compute diff = s − e in 33 bits and deviation = |diff|. The result is at most 2^32−2, so it fits in 32 bits with no saturation.
- `anomaly` = (deviation > `threshold`), strictly greater, AND state ≠ WARMUP.
- Mode FSM:
  - **WARMUP** (reset state): a warm-up counter increments on each EVAL. When EVAL number `WARMUP` completes, go to ARMED. That decision itself is still forced non-anomalous.
  - **ARMED:**
    - On an anomalous EVAL: `anomaly_run`++ (saturating).
    - On a non-anomalous EVAL: `anomaly_run` ← 0.
    - When `anomaly_run` reaches `ALARM_RUN`, set `alarm`=1 and go to ALARM.
  - **ALARM:**
    - `alarm` stays 1. `anomaly_run` keeps counting and resetting exactly as in ARMED.
    - On `alarm_clr`: `alarm` ← 0, `anomaly_run` ← 0, go to ARMED.
- Boundary rules:
  - `alarm_clr` while in WARMUP or ARMED clears `anomaly_run` only.
  - `alarm_clr` in the same cycle as an EVAL: clear wins. `anomaly_run` ← 0 and no alarm is raised that cycle. `anomaly` and `decision_valid` are still reported normally.
  - `threshold` is sampled at EVAL, not at capture.
  - `rst_h` low at any point aborts any in-flight decision, with no `decision_valid` afterwards, and returns to WARMUP.

## Timing
- Reset values:
  - `decision_valid`=0, `anomaly`=0, `deviation`=0, `anomaly_run`=0, `alarm`=0, `total_cnt`=0, `anom_cnt`=0.
  - FSM state = WARMUP, warm-up counter = 0.
- Latency: `EnableDecision` high in cycle t → `decision_valid`, `anomaly` and `deviation` updated in cycle t+2.
- `anomaly_run` and `alarm` update in the same cycle t+2.
- `anomaly` and `deviation` hold their values until the next decision. `decision_valid` is high only in cycle t+2.
- Back-to-back pulses in t and t+1 produce `decision_valid` in t+2 and t+3.
- `alarm` falls in the cycle after the edge that samples `alarm_clr`.

## Configuration
- Macro: `DECISION_STATS_EN`.
- With the macro defined:
  - `total_cnt` increments on every EVAL, including WARMUP.
  - `anom_cnt` increments on every anomalous EVAL.
  - Both saturate at 0xFFFF and clear only on reset.
- Without the macro: both outputs are tied to 0 and no counter flops are synthesized.

## Test plan
- **Reset and warm-up:** use `WARMUP`=2 and `threshold`=10. Drive `ewma_rssi`=0x8000_0050 (−80) and `rssi`=0x8000_0064 (−100) for 2 pulses.
  - Required: `deviation`=20 and `anomaly`=0 on both.
  - On the 3rd pulse: `anomaly`=1, `anomaly_run`=1.
- **Latency/back-to-back:** pulses in cycles 10 and 11.
  - Required: `decision_valid` high in cycles 12 and 13 only, each with correct `deviation`.
- **Sign handling:** `ewma_rssi`=0x8000_0005 (−5), `rssi`=0x0000_0003 (+3) → `deviation`=8.
  - −0 against +0 → `deviation`=0.
  - `threshold`=8 → `anomaly`=0, because the comparison is strict.
- **Alarm:** `ALARM_RUN`=3, after warm-up.
  - Three anomalous pulses → `alarm`=1 in the cycle of the third `decision_valid`.
  - A normal pulse → `anomaly_run`=0 and `alarm` stays 1.
  - `alarm_clr` → `alarm`=0.
- **Clear collision:** `alarm_clr` asserted in the same cycle as the EVAL of the third anomaly.
  - Required: `anomaly`=1, `anomaly_run`=0, `alarm` stays 0.
- **Reset mid-operation:** pull `rst_h` low in the cycle after a pulse.
  - Required: no `decision_valid` follows, all outputs are 0, and the FSM is back in WARMUP.
  - With `DECISION_STATS_EN`: 5 decisions with 2 anomalies → `total_cnt`=5, `anom_cnt`=2.
